// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch front-end for the single-cycle core. It owns the fetch PC,
// issues in-order requests on a pipelined memory port, and buffers returned
// words together with their PCs in a small prefetch FIFO. The core drains the
// FIFO through a valid/ready handshake. A redirect from the core flushes the
// FIFO and arranges for every response still in flight to be discarded.
//
// Handshake rule (both request and instruction ports): a transfer happens on a
// rising edge where valid && ready are both high; valid never depends on ready
// of the same port, and the payload is held stable while valid && !ready.
// The response port has no back-pressure: imem_rsp_valid is taken every cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_req_*        request to instruction memory (valid/ready/addr)
//   imem_rsp_*        in-order response from memory (valid/data)
//   if_*              instruction to the core (valid/ready/instr/pc)
//   redirect_*        flush and restart fetch at redirect_pc
//   fetch_misaligned  (only with IFETCH_MISALIGN_TRAP_EN) sticky flag set by a
//                     redirect to a non word-aligned target
//
// Build option:
//   IFETCH_MISALIGN_TRAP_EN  when defined, a misaligned redirect flushes, raises
//                            fetch_misaligned and stops fetching until an
//                            aligned redirect or reset. When undefined, the low
//                            two redirect bits are silently cleared.
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int               XLEN       = 64,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [XLEN-1:0]  if_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic             fetch_misaligned,
`endif
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     instr_mem_d [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_d [FIFO_DEPTH];
    ptr_t            rd_ptr_q, rd_ptr_d;
    ptr_t            wr_ptr_q, wr_ptr_d;
    cnt_t            count_q, count_d;
    cnt_t            outstanding_q, outstanding_d;
    cnt_t            drop_q, drop_d;

    // ------------------------------------------------------------------
    // Redirect target and optional misalignment trap
    // ------------------------------------------------------------------
    logic [XLEN-1:0] redirect_target;
    logic            fetch_inhibit;

    assign redirect_target = redirect_pc & ~XLEN'(3);

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    assign fetch_inhibit    = misaligned_q;
    assign fetch_misaligned = misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            misaligned_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign fetch_inhibit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Credits: a request is only issued if its eventual response is sure to
    // find a FIFO slot, counting every entry already buffered or in flight.
    logic [CW:0] credits_used;
    logic        credit_ok;
    logic        req_fire;
    logic        rsp_push;
    logic        if_pop;
    cnt_t        req_inc;
    cnt_t        rsp_dec;

    assign credits_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit_ok    = credits_used < {1'b0, DEPTH_C};

    assign imem_req_valid = !rst && !redirect_valid && credit_ok && !fetch_inhibit;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only if no flush is pending against it and no flush
    // is happening in this very cycle.
    assign rsp_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    assign if_valid = (count_q != '0) && !fetch_inhibit;
    assign if_instr = instr_mem_q[rd_ptr_q];
    assign if_pc    = pc_mem_q[rd_ptr_q];
    assign if_pop   = if_valid && if_ready && !redirect_valid;

    assign req_inc = req_fire       ? CNT_ONE : '0;
    assign rsp_dec = imem_rsp_valid ? CNT_ONE : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + req_inc - rsp_dec;

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this edge belongs to the old
            // stream. Nothing is issued during a redirect, so that is exactly
            // the outstanding count minus a response consumed right now.
            drop_d     = outstanding_q - rsp_dec;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end

            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_ONE;
            end

            if (rsp_push) begin
                instr_mem_d[wr_ptr_q] = imem_rsp_data;
                pc_mem_d[wr_ptr_q]    = rsp_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
                rsp_pc_d              = rsp_pc_q + XLEN'(4);
            end

            if (if_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            count_d = count_q + (rsp_push ? CNT_ONE : '0) - (if_pop ? CNT_ONE : '0);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

endmodule
